// File: rtl/counter_bank_pkg.sv
// Shared types and constants for the counter bank.
package counter_bank_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // A one-channel bank still needs a one-bit channel select.
    function automatic int cfg_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/counter_bank_ch.sv
// One counter channel: value, terminal limit, overflow mode, tc/ovf flags.
// Saturate mode exists only when COUNTER_BANK_SAT_EN is defined; otherwise the channel always wraps.
module counter_bank_ch
    import counter_bank_pkg::*;
#(
    parameter int N      = 8,
    parameter int STEP_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cfg_we,
    input  logic [N-1:0]      i_cfg_limit,
    input  logic              i_cfg_sat,
    input  logic              i_en,
    input  logic              i_load,
    input  logic              i_dir,
    input  logic [STEP_W-1:0] i_step,
    input  logic [N-1:0]      i_data,
    input  logic              i_ovf_clr,
    output logic [N-1:0]      o_value,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_tc,
    output logic              o_ovf
);

    localparam logic [N:0] ONE_X = {{N{1'b0}}, 1'b1};

    logic [N-1:0] ps;
    logic [N-1:0] lim;
    mode_e        mode;

    logic [N:0]   ps_x, lim_x, step_x;
    logic [N:0]   sum_up, wrap_up, wrap_dn;
    logic [N-1:0] ps_nxt;
    logic         boundary;
    logic         count_evt;

`ifdef COUNTER_BANK_SAT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode <= MODE_WRAP;
        end else if (i_cfg_we) begin
            mode <= i_cfg_sat ? MODE_SAT : MODE_WRAP;
        end
    end
`else
    logic unused_cfg_sat;
    assign unused_cfg_sat = i_cfg_sat;
    assign mode           = MODE_WRAP;
`endif

    // Arithmetic carried in N+1 bits so the carry/borrow is visible.
    assign ps_x    = {1'b0, ps};
    assign lim_x   = {1'b0, lim};
    assign step_x  = (N+1)'(i_step);
    assign sum_up  = ps_x + step_x;
    assign wrap_up = sum_up - lim_x - ONE_X;
    assign wrap_dn = ps_x + lim_x + ONE_X - step_x;

    always_comb begin
        ps_nxt   = ps;
        boundary = 1'b0;
        if (i_dir == DIR_UP) begin
            if (sum_up <= lim_x) begin
                ps_nxt = sum_up[N-1:0];
            end else begin
                boundary = 1'b1;
                if (mode == MODE_SAT)      ps_nxt = lim;
                else if (wrap_up > lim_x)  ps_nxt = lim;
                else                       ps_nxt = wrap_up[N-1:0];
            end
        end else begin
            if (ps_x >= step_x) begin
                ps_nxt = ps - step_x[N-1:0];
            end else begin
                boundary = 1'b1;
                if (mode == MODE_SAT)      ps_nxt = '0;
                else if (wrap_dn > lim_x)  ps_nxt = lim;
                else                       ps_nxt = wrap_dn[N-1:0];
            end
        end
    end

    assign count_evt = i_en && !i_load && !i_cfg_we && boundary;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ps    <= '0;
            lim   <= '1;
            o_tc  <= 1'b0;
            o_ovf <= 1'b0;
        end else begin
            // A config write to this channel swallows any load/count in the same cycle.
            if (i_cfg_we) begin
                lim <= i_cfg_limit;
                if (ps > i_cfg_limit) ps <= i_cfg_limit;
            end else if (i_en && i_load) begin
                ps <= (i_data > lim) ? lim : i_data;
            end else if (i_en) begin
                ps <= ps_nxt;
            end
            o_tc <= count_evt;
            if (count_evt)      o_ovf <= 1'b1;
            else if (i_ovf_clr) o_ovf <= 1'b0;
        end
    end

    assign o_value = ps;
    assign o_full  = (ps == lim);
    assign o_empty = (ps == '0);

endmodule

// File: rtl/counter_bank.sv
// Bank of CH up/down counters sharing one config port; decodes config writes and packs outputs.
// Build option COUNTER_BANK_SAT_EN enables per-channel saturate mode (default: all channels wrap).
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int N      = 8,
    parameter int CH     = 4,
    parameter int STEP_W = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [CH-1:0]             i_en,
    input  logic [CH-1:0]             i_load,
    input  logic [CH-1:0]             i_dir,
    input  logic [STEP_W-1:0]         i_step,
    input  logic [N-1:0]              i_data,
    input  logic                      i_cfg_we,
    input  logic [cfg_width(CH)-1:0]  i_cfg_ch,
    input  logic [N-1:0]              i_cfg_limit,
    input  logic                      i_cfg_sat,
    input  logic [CH-1:0]             i_ovf_clr,
    output logic [CH*N-1:0]           o_result,
    output logic [CH-1:0]             o_full,
    output logic [CH-1:0]             o_empty,
    output logic [CH-1:0]             o_tc,
    output logic [CH-1:0]             o_ovf
);

    localparam int CFG_W = cfg_width(CH);

    logic [CH-1:0] cfg_hit;

    // Channel indices at or above CH never match, so such writes are dropped.
    always_comb begin
        cfg_hit = '0;
        for (int c = 0; c < CH; c++) begin
            cfg_hit[c] = i_cfg_we && (i_cfg_ch == CFG_W'(c));
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        counter_bank_ch #(
            .N      (N),
            .STEP_W (STEP_W)
        ) u_ch (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_cfg_we    (cfg_hit[c]),
            .i_cfg_limit (i_cfg_limit),
            .i_cfg_sat   (i_cfg_sat),
            .i_en        (i_en[c]),
            .i_load      (i_load[c]),
            .i_dir       (i_dir[c]),
            .i_step      (i_step),
            .i_data      (i_data),
            .i_ovf_clr   (i_ovf_clr[c]),
            .o_value     (o_result[c*N +: N]),
            .o_full      (o_full[c]),
            .o_empty     (o_empty[c]),
            .o_tc        (o_tc[c]),
            .o_ovf       (o_ovf[c])
        );
    end

endmodule

// File: tb/tb_counter_bank.sv
// Testbench for counter_bank: directed scenarios plus random traffic, scored against an integer model.
module tb_counter_bank;
    import counter_bank_pkg::*;

    localparam int N      = 8;
    localparam int CH     = 4;
    localparam int STEP_W = 4;
    localparam int CW     = cfg_width(CH);
`ifdef COUNTER_BANK_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [CH-1:0]     i_en, i_load, i_dir, i_ovf_clr;
    logic [STEP_W-1:0] i_step;
    logic [N-1:0]      i_data, i_cfg_limit;
    logic              i_cfg_we, i_cfg_sat;
    logic [CW-1:0]     i_cfg_ch;
    logic [CH*N-1:0]   o_result;
    logic [CH-1:0]     o_full, o_empty, o_tc, o_ovf;

    counter_bank #(.N(N), .CH(CH), .STEP_W(STEP_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(i_en), .i_load(i_load), .i_dir(i_dir),
        .i_step(i_step), .i_data(i_data), .i_cfg_we(i_cfg_we), .i_cfg_ch(i_cfg_ch),
        .i_cfg_limit(i_cfg_limit), .i_cfg_sat(i_cfg_sat), .i_ovf_clr(i_ovf_clr),
        .o_result(o_result), .o_full(o_full), .o_empty(o_empty), .o_tc(o_tc), .o_ovf(o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [CH*N-1:0] res;
        logic [CH-1:0]   full, empty, tc, ovf;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    int m_ps[CH], m_lim[CH], m_tc[CH], m_ovf[CH];
    bit m_sat[CH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_ps[c] = 0; m_lim[c] = (1 << N) - 1; m_sat[c] = 1'b0; m_tc[c] = 0; m_ovf[c] = 0;
        end
    endtask

    function automatic int clamp_lim(input int v, input int lim);
        return (v < 0 || v > lim) ? lim : v;
    endfunction

    // Advance the model by one clock edge using the inputs now on the pins.
    task automatic commit();
        exp_t e;
        for (int c = 0; c < CH; c++) begin
            int nps;
            int stp;
            bit ev;
            nps = m_ps[c];
            stp = int'(i_step);
            ev  = 1'b0;
            if (i_cfg_we && int'(i_cfg_ch) == c) begin
                m_lim[c] = int'(i_cfg_limit);
                m_sat[c] = SAT_ON && i_cfg_sat;
                if (nps > m_lim[c]) nps = m_lim[c];
            end else if (i_en[c] && i_load[c]) begin
                nps = (int'(i_data) > m_lim[c]) ? m_lim[c] : int'(i_data);
            end else if (i_en[c]) begin
                if (i_dir[c]) begin
                    if (m_ps[c] + stp <= m_lim[c]) nps = m_ps[c] + stp;
                    else begin
                        ev  = 1'b1;
                        nps = m_sat[c] ? m_lim[c] : clamp_lim(m_ps[c] + stp - m_lim[c] - 1, m_lim[c]);
                    end
                end else begin
                    if (m_ps[c] >= stp) nps = m_ps[c] - stp;
                    else begin
                        ev  = 1'b1;
                        nps = m_sat[c] ? 0 : clamp_lim(m_ps[c] + m_lim[c] + 1 - stp, m_lim[c]);
                    end
                end
            end
            m_ps[c] = nps;
            m_tc[c] = ev ? 1 : 0;
            if (ev) m_ovf[c] = 1;
            else if (i_ovf_clr[c]) m_ovf[c] = 0;
            e.res[c*N +: N] = N'(m_ps[c]);
            e.full[c]  = (m_ps[c] == m_lim[c]);
            e.empty[c] = (m_ps[c] == 0);
            e.tc[c]    = m_tc[c][0];
            e.ovf[c]   = m_ovf[c][0];
        end
        q.push_back(e);
    endtask

    task automatic drive_idle();
        i_en = '0; i_load = '0; i_dir = '0; i_ovf_clr = '0; i_step = '0; i_data = '0;
        i_cfg_we = 1'b0; i_cfg_ch = '0; i_cfg_limit = '0; i_cfg_sat = 1'b0;
    endtask

    // Inputs change just after the falling edge, once the monitor has sampled.
    task automatic slot();
        @(negedge clk);
        #1;
        drive_idle();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_result"}, o_result, '0);
        check({tag, "_empty"},  o_empty, {CH{1'b1}});
        check({tag, "_full"},   o_full, '0);
        check({tag, "_tc"},     o_tc, '0);
        check({tag, "_ovf"},    o_ovf, '0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && q.size() > 0) begin
                e = q.pop_front();
                check("sb_result", o_result, e.res);
                check("sb_full",   o_full,   e.full);
                check("sb_empty",  o_empty,  e.empty);
                check("sb_tc",     o_tc,     e.tc);
                check("sb_ovf",    o_ovf,    e.ovf);
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int drain;
        rst = 1'b1;
        drive_idle();
        model_reset();
        #12;
        check_reset_state("init");
        #1 rst = 1'b0;

        // Reset while channel 0 holds 37 and is counting.
        slot(); i_en[0] = 1'b1; i_load[0] = 1'b1; i_data = 8'd37; commit();
        slot(); check("load37", o_result[7:0], 8'd37);
        i_en[0] = 1'b1; i_dir[0] = DIR_UP; i_step = 4'd1; commit();
        #2 rst = 1'b1;
        #1 check_reset_state("midrst");
        drive_idle();
        q.delete();
        model_reset();
        rst = 1'b0;

        // Wrap up on channel 0.
        slot(); i_cfg_we = 1'b1; i_cfg_ch = 2'd0; i_cfg_limit = 8'd9; commit();
        slot(); i_en[0] = 1'b1; i_load[0] = 1'b1; i_data = 8'd8; commit();
        slot(); i_en[0] = 1'b1; i_dir[0] = DIR_UP; i_step = 4'd3; commit();
        slot(); check("wrapup_ps", o_result[7:0], 8'd1);
        check("wrapup_tc", o_tc[0], 1'b1);
        check("wrapup_ovf", o_ovf[0], 1'b1);
        commit();
        slot(); check("wrapup_tc_gone", o_tc[0], 1'b0);
        commit();

`ifdef COUNTER_BANK_SAT_EN
        slot(); i_cfg_we = 1'b1; i_cfg_ch = 2'd0; i_cfg_limit = 8'd9; i_cfg_sat = 1'b1; commit();
        slot(); i_en[0] = 1'b1; i_load[0] = 1'b1; i_data = 8'd8; commit();
        slot(); i_en[0] = 1'b1; i_dir[0] = DIR_UP; i_step = 4'd3; commit();
        slot(); check("sat_ps", o_result[7:0], 8'd9);
        check("sat_full", o_full[0], 1'b1);
        check("sat_tc", o_tc[0], 1'b1);
        i_en[0] = 1'b1; i_dir[0] = DIR_UP; i_step = 4'd3; commit();
        slot(); check("sat_again_ps", o_result[7:0], 8'd9);
        check("sat_again_tc", o_tc[0], 1'b1);
        commit();
`endif

        // Wrap down on channel 1, then step 0.
        slot(); i_cfg_we = 1'b1; i_cfg_ch = 2'd1; i_cfg_limit = 8'd9; commit();
        slot(); i_en[1] = 1'b1; i_load[1] = 1'b1; i_data = 8'd1; commit();
        slot(); i_en[1] = 1'b1; i_dir[1] = DIR_DOWN; i_step = 4'd3; commit();
        slot(); check("wrapdn_ps", o_result[15:8], 8'd8);
        check("wrapdn_tc", o_tc[1], 1'b1);
        i_en[1] = 1'b1; i_dir[1] = DIR_DOWN; i_step = 4'd0; commit();
        slot(); check("step0_ps", o_result[15:8], 8'd8);
        check("step0_tc", o_tc[1], 1'b0);
        commit();

        // Config write wins over a same-cycle count on channel 2.
        slot(); i_en[2] = 1'b1; i_load[2] = 1'b1; i_data = 8'd200; commit();
        slot(); i_en[2] = 1'b1; i_dir[2] = DIR_UP; i_step = 4'd1;
        i_cfg_we = 1'b1; i_cfg_ch = 2'd2; i_cfg_limit = 8'd100; commit();
        slot(); check("cfgwin_ps", o_result[23:16], 8'd100);
        check("cfgwin_full", o_full[2], 1'b1);
        check("cfgwin_tc", o_tc[2], 1'b0);
        commit();

        // Load clamp and overflow clear on channel 3.
        slot(); i_cfg_we = 1'b1; i_cfg_ch = 2'd3; i_cfg_limit = 8'd100; commit();
        slot(); i_en[3] = 1'b1; i_load[3] = 1'b1; i_data = 8'd250; commit();
        slot(); check("clamp_ps", o_result[31:24], 8'd100);
        i_en[3] = 1'b1; i_dir[3] = DIR_UP; i_step = 4'd5; i_ovf_clr[3] = 1'b1; commit();
        slot(); check("setwins_ovf", o_ovf[3], 1'b1);
        check("setwins_ps", o_result[31:24], 8'd4);
        i_ovf_clr[3] = 1'b1; commit();
        slot(); check("clr_ovf", o_ovf[3], 1'b0);
        commit();

        // Random traffic; small limits are favoured so boundaries are hit often.
        for (int i = 0; i < 2000; i++) begin
            slot();
            i_en      = CH'($urandom);
            i_load    = CH'($urandom & $urandom & $urandom);
            i_dir     = CH'($urandom);
            i_step    = STEP_W'($urandom);
            i_data    = N'($urandom);
            i_ovf_clr = CH'($urandom & $urandom);
            i_cfg_we  = ($urandom_range(0, 7) == 0);
            i_cfg_ch  = CW'($urandom);
            i_cfg_sat = 1'($urandom);
            i_cfg_limit = ($urandom_range(0, 3) == 0) ? N'($urandom) : N'($urandom_range(0, 20));
            commit();
        end

        slot();
        drain = 0;
        while (q.size() > 0 && drain < 5) begin
            @(negedge clk); #1;
            drain++;
        end
        check("drain_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_bank.md
# counter_bank

Parametrised bank of CH independent up/down counters, each with a programmable terminal value, variable step and wrap or saturate overflow handling. Successor to the single fixed-range counter. Used wherever several event or position counters share one clock domain and one configuration port. Provides per-channel full/empty, terminal-count pulse and sticky overflow flags.

## Interface
- N, 8, counter width per channel
- CH, 4, number of channels (≥1)
- STEP_W, 4, width of step input (STEP_W ≤ N)
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_en  in  CH  per-channel enable
- i_load  in  CH  per-channel load request; effective only with i_en
- i_dir  in  CH  per-channel direction, 1 = up, 0 = down
- i_step  in  STEP_W  step magnitude, shared by all channels
- i_data  in  N  load value, shared
- i_cfg_we  in  1  configuration write strobe
- i_cfg_ch  in  $clog2(CH) (min 1)  configuration target channel
- i_cfg_limit  in  N  terminal value written on i_cfg_we
- i_cfg_sat  in  1  mode written on i_cfg_we, 1 = saturate, 0 = wrap
- i_ovf_clr  in  CH  per-channel sticky overflow clear
- o_result  out  CH*N  counter values, channel c at [c*N +: N]
- o_full  out  CH  ps[c] == limit[c]
- o_empty  out  CH  ps[c] == 0
- o_tc  out  CH  terminal-count pulse, registered
- o_ovf  out  CH  sticky boundary-crossing flag

## Operation
- Per channel c: state ps[c], limit[c], mode[c]. Legal range 0..limit[c].
- Reset (async assert): ps = 0, limit = all ones, mode = wrap, o_tc = 0, o_ovf = 0. Hence o_empty = all ones, o_full = 0.
- Priority per channel per edge: config write to c > i_en&i_load > i_en count > hold.
- Config write: limit[c] and mode[c] updated. ps[c] <= min(ps[c], new limit). The count/load for c in that cycle is dropped.
- Load: ps <= min(i_data, limit). No o_tc, no o_ovf.
- Count up: sum = ps + step, computed in N+1 bits.
  - If sum ≤ limit: ps <= sum.
  - Otherwise a boundary event occurs. Wrap: ps <= sum − (limit+1), clamped to limit if still > limit. Saturate: ps <= limit.
- Count down:
  - If ps ≥ step: ps <= ps − step.
  - Otherwise a boundary event occurs. Wrap: ps <= ps + limit + 1 − step (N+1 bits), clamped to limit. Saturate: ps <= 0.
- Step 0: ps holds; never a boundary event.
- Boundary event: o_tc[c] high for exactly the next cycle, and o_ovf[c] set.
- o_ovf: i_ovf_clr clears it; a set in the same cycle wins over the clear.
- Saturated channel held at limit (up) or 0 (down): every further nonzero step is a boundary event.
- i_cfg_ch ≥ CH: write ignored.

## Timing
- All state updates on the rising edge of i_clk; reset is immediate.
- o_result, o_full, o_empty: valid one cycle after the enabling edge; combinational from registers only.
- o_tc, o_ovf: registered, aligned with the updated o_result.
- No combinational path from any input to any output.
- Configuration takes effect at the edge where i_cfg_we is sampled.

## Configuration
- COUNTER_BANK_SAT_EN defined: mode[c] register present; i_cfg_sat honoured.
- Not defined: mode register removed; all channels wrap; i_cfg_sat ignored, but the port remains.

## Structure
- counter_bank_pkg holds:
  - enum mode_e {MODE_WRAP, MODE_SAT}
  - constants DIR_UP = 1'b1, DIR_DOWN = 1'b0
- Sub-module counter_bank_ch: one channel (ps, limit, mode, next-state arithmetic, tc/ovf registers), instantiated CH times by generate.
- Top: config decode, bus packing.

## Test plan
- N=8. Reset mid-count (ps[0]=37) → all o_result 0, o_empty all ones, o_ovf 0, before the next clock edge.
- Wrap up: limit[0]=9, ps=8, step=3, up, en → ps=1, o_tc[0] one cycle, o_ovf[0]=1.
- Saturate (macro on): limit=9, ps=8, step=3, up → ps=9, o_full=1. Repeat → ps=9, o_tc again.
- Wrap down: limit=9, ps=1, step=3, down → ps=8. Step=0 → ps holds, no o_tc.
- Config vs count: ps[2]=200, en+up with cfg write limit=100 to channel 2 in the same cycle → ps=100, o_full[2]=1, no o_tc.
- Load clamp and ovf clear: limit=100, load i_data=250 → ps=100. Assert i_ovf_clr together with a boundary event → o_ovf stays 1. i_ovf_clr alone → o_ovf 0.
